// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    STEP   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int CNT_W_DEFAULT = 24;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous level; a level held through reset gives no edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Turns debounced step/mode buttons into a one-cycle CPU clock enable with
// single-step, auto-repeat, free-run and halt behaviour.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int               CNT_W         = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] RUN_DIV       = 24'd50000,
  parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn,
  input  logic mode_btn,
  input  logic halt,
  output logic cpu_ce,
  output logic running,
  output logic halted
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LAST   = RUN_DIV - ONE;
  localparam logic [CNT_W-1:0] REP_LAST   = REPEAT_DELAY - ONE;
  // Reloading here makes the next terminal count REPEAT_PERIOD cycles away.
  localparam logic [CNT_W-1:0] REP_RELOAD = REPEAT_DELAY - REPEAT_PERIOD;

  logic step_rise;
  logic mode_rise;

  rise_detect u_step_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (step_btn),
    .rise  (step_rise)
  );

  rise_detect u_mode_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (mode_btn),
    .rise  (mode_rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_ce_q, cpu_ce_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cpu_ce_d = 1'b0;
    case (state_q)
      STEP: begin
        if (halt) begin
          state_d = HALTED;
          cnt_d   = '0;
        end else if (mode_rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (step_rise) begin
          state_d  = HOLD;
          cnt_d    = '0;
          cpu_ce_d = 1'b1;
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALTED;
          cnt_d   = '0;
        end else if (mode_rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (!step_btn) begin
          state_d = STEP;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = REP_RELOAD;
          cpu_ce_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
          cnt_d   = '0;
        end else if (mode_rise) begin
          state_d = STEP;
          cnt_d   = '0;
        end else if (cnt_q == RUN_LAST) begin
          cnt_d    = '0;
          cpu_ce_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HALTED: begin
        // Button edges seen on the exit cycle are deliberately dropped.
        cnt_d = '0;
        if (!halt) begin
          state_d = STEP;
        end
      end
      default: begin
        state_d = STEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STEP;
      cnt_q    <= '0;
      cpu_ce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpu_ce_q <= cpu_ce_d;
    end
  end

  assign cpu_ce  = cpu_ce_q;
  assign running = (state_q == RUN);
  assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with RUN_DIV=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_cpu_clock_ctrl;

  logic clk;
  logic rst_n;
  logic step_btn;
  logic mode_btn;
  logic halt;
  logic cpu_ce;
  logic running;
  logic halted;

  int total = 0;
  int bad   = 0;

  cpu_clock_ctrl #(
    .CNT_W         (24),
    .RUN_DIV       (24'd4),
    .REPEAT_DELAY  (24'd10),
    .REPEAT_PERIOD (24'd3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_btn (step_btn),
    .mode_btn (mode_btn),
    .halt     (halt),
    .cpu_ce   (cpu_ce),
    .running  (running),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      $error("check %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clk edge, then check the registered outputs 1 time unit later.
  task automatic cyc(input string tag, input logic e_ce, input logic e_run, input logic e_hlt);
    @(posedge clk);
    #1;
    chk({tag, ".ce"},  cpu_ce,  e_ce);
    chk({tag, ".run"}, running, e_run);
    chk({tag, ".hlt"}, halted,  e_hlt);
  endtask

  initial begin
    rst_n    = 1'b0;
    step_btn = 1'b1;
    mode_btn = 1'b0;
    halt     = 1'b0;

    // Reset with step held through it
    cyc("reset0", 1'b0, 1'b0, 1'b0);
    cyc("reset1", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("held_after_reset", 1'b0, 1'b0, 1'b0);
    step_btn = 1'b0;
    for (int i = 0; i < 2; i++) cyc("step_low", 1'b0, 1'b0, 1'b0);

    // Step press and auto-repeat: pulses at k+1, k+11, k+14, k+17, k+20
    step_btn = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      logic e;
      e = (j == 1) || (j == 11) || (j == 14) || (j == 17) || (j == 20);
      cyc($sformatf("hold_j%0d", j), e, 1'b0, 1'b0);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 5; i++) cyc("released", 1'b0, 1'b0, 1'b0);

    // Run mode: pulses at j=5 and j=9, step rises ignored, mode rise at j=13 stops
    mode_btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      logic e;
      if (j == 2) mode_btn = 1'b0;
      if (j == 3 || j == 7) step_btn = 1'b1;
      if (j == 4 || j == 8) step_btn = 1'b0;
      e = (j == 5) || (j == 9);
      cyc($sformatf("run_j%0d", j), e, 1'b1, 1'b0);
    end
    mode_btn = 1'b1;
    cyc("run_exit", 1'b0, 1'b0, 1'b0);
    mode_btn = 1'b0;
    for (int i = 0; i < 6; i++) cyc("step_after_run", 1'b0, 1'b0, 1'b0);

    // Halt in RUN on the cycle a pulse is due
    mode_btn = 1'b1;
    cyc("run2_j1", 1'b0, 1'b1, 1'b0);
    mode_btn = 1'b0;
    for (int j = 2; j <= 4; j++) cyc($sformatf("run2_j%0d", j), 1'b0, 1'b1, 1'b0);
    halt = 1'b1;
    cyc("halt_entry", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cyc("halted", 1'b0, 1'b0, 1'b1);
    halt     = 1'b0;
    step_btn = 1'b1;
    mode_btn = 1'b1;
    cyc("halt_exit", 1'b0, 1'b0, 1'b0);
    cyc("halt_exit_edges_dropped", 1'b0, 1'b0, 1'b0);
    step_btn = 1'b0;
    mode_btn = 1'b0;
    cyc("idle", 1'b0, 1'b0, 1'b0);

    // Step rise and halt on the same edge
    step_btn = 1'b1;
    halt     = 1'b1;
    cyc("step_and_halt", 1'b0, 1'b0, 1'b1);
    halt = 1'b0;
    cyc("halt_release_step_held", 1'b0, 1'b0, 1'b0);
    step_btn = 1'b0;
    cyc("idle2", 1'b0, 1'b0, 1'b0);

    // Reset in HOLD two cycles before the first repeat pulse
    step_btn = 1'b1;
    cyc("hold2_j1", 1'b1, 1'b0, 1'b0);
    for (int j = 2; j <= 9; j++) cyc($sformatf("hold2_j%0d", j), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc("reset_in_hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("after_reset_held", 1'b0, 1'b0, 1'b0);
    step_btn = 1'b0;
    cyc("after_reset_release", 1'b0, 1'b0, 1'b0);
    step_btn = 1'b1;
    cyc("after_reset_press", 1'b1, 1'b0, 1'b0);
    step_btn = 1'b0;
    cyc("final", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
